mem_config_queue: RTL and testbench
===================================

// Module: mem_config_queue
// PURPOSE
//  Per-stream memory-buffer configuration with queuing: software writes (vaddr, size) pairs over the config bus.
//  Each pair is committed into a per-stream descriptor FIFO of DEPTH entries, so several buffers can be posted ahead of the consumer.
//  Adds readable status, flush, sticky error flags and zero-size rejection.
//  Sits between the config_i slave port and the per-stream mem_config_i masters feeding the DMA/stream engines.
// PARAMETERS
//  NUM_STREAMS  1   number of independent buffer streams
//  DEPTH        4   descriptor FIFO entries per stream; power of two, >=2
//  ADDR_OFFSET  0   first config register index owned by this block
// PORTS
//  clk    in   1                        clock
//  rst_n  in   1                        asynchronous active-low reset
//  conf   -    config_i.s               config bus slave: write addr/data/valid, read addr/data
//  out    -    mem_config_i.m[NUM_STREAMS]  buffer ready/valid, payload buffer_t {vaddr, size}
// BEHAVIOUR
//  Register map: stream I occupies ADDR_OFFSET + 4*I + {0,1,2,3}; addresses outside the range are ignored.
//   +0 VADDR (W): stages vaddr and sets staged flag; a second write before SIZE overwrites it.
//   +1 SIZE (W): commits {staged vaddr, size} and clears the staged flag.
//   +2 STATUS (R): [7:0] occupancy, [8] staged, [9] ERR_OVF, [10] ERR_NOVADDR, [11] ERR_ZERO.
//   +3 CTRL (W): bit0 flush, bit1 clear all error flags; other bits ignored.
//  Commit rules, evaluated in the SIZE write cycle:
//   - staged=0: drop the write, set ERR_NOVADDR.
//   - size==0: drop the write, set ERR_ZERO, clear staged.
//   - FIFO full after any same-cycle pop: drop the write, set ERR_OVF, clear staged.
//   - Otherwise push the pair.
//   Error flags are sticky until CTRL bit1 or reset.
//  Latency: SIZE write in cycle N -> out[I].buffer.valid in N+1 if the FIFO was empty.
//  Output: valid = !empty; payload = FIFO head; pop on valid&&ready.
//   - Payload is stable while valid && !ready. Order is FIFO.
//   - Simultaneous push and pop when full: both occur (occupancy unchanged).
//  Flush (CTRL bit0): at the next edge, occupancy=0, staged=0, valid=0; error flags are kept.
//   - A handshake in the flush cycle is complete for the consumer, and that entry is discarded.
//   - Flush and clear together: both apply.
//  Reads: STATUS data returned with 1-cycle latency and reflects state before that cycle's edge.
//   - Unmapped reads return 0.
//  Reset (async assert, sync deassert expected upstream): every out valid=0, payload=0, occupancy=0, staged=0, flags=0, read data=0.
//   - Reset mid-transfer discards all queued descriptors.
//  Pointers are log2(DEPTH) bits and wrap naturally; occupancy counter is log2(DEPTH)+1 bits, saturating never needed by the rules above.
// STRUCTURE
//  libstf package: vaddress_t, alloc_size_t, buffer_t (existing).
//   - Add MEM_CFG_REGS_PER_STREAM=4.
//   - Add mem_cfg_status_t packed struct (occupancy, staged, ovf, novaddr, zero).
//  Sub-module mem_config_queue_channel: one stream's staged vaddr, FIFO, flags and status.
//   - Generated NUM_STREAMS times.
//  Top-level: address decode + read mux.
// TESTING
//  1 Write VADDR=0x1000, SIZE=0x40 to stream 0 -> valid next cycle, payload {0x1000,0x40}; STATUS occ=1.
//  2 DEPTH=4, ready=0, post 5 pairs -> first 4 queued in order.
//    - 5th dropped with ERR_OVF=1.
//    - Raise ready -> 4 pops in order, then valid=0.
//  3 SIZE=0x20 with no prior VADDR -> no push, ERR_NOVADDR=1.
//    - SIZE=0 after VADDR -> no push, ERR_ZERO=1, staged=0.
//    - CTRL=2 -> all flags 0.
//  4 Full FIFO, ready=1, SIZE write in same cycle -> push accepted, occ stays 4, no ERR_OVF.
//  5 Queue 3 entries, CTRL=1 -> next cycle valid=0, occ=0.
//    - Flags unchanged; new pair then flows normally.
//  6 NUM_STREAMS=3: interleave writes to streams 0 and 2 -> no cross-talk.
//    - Assert rst_n=0 mid-stream -> all valids drop immediately, STATUS reads 0.

Source files
------------

// File: rtl/mem_config_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_config_queue_pkg
// Description : Shared types for the per-stream buffer configuration queue.
// Revision    : 1.0
// ============================================================================
package mem_config_queue_pkg;

    localparam int VADDR_W    = 48;
    localparam int SIZE_W     = 32;
    localparam int CFG_ADDR_W = 8;
    localparam int CFG_DATA_W = 64;

    localparam int MEM_CFG_REGS_PER_STREAM = 4;

    typedef logic [VADDR_W-1:0] vaddress_t;
    typedef logic [SIZE_W-1:0]  alloc_size_t;

    typedef struct packed {
        vaddress_t   vaddr;
        alloc_size_t size;
    } buffer_t;

    // Field order gives the STATUS register layout, occupancy in the low byte.
    typedef struct packed {
        logic       zero;
        logic       novaddr;
        logic       ovf;
        logic       staged;
        logic [7:0] occupancy;
    } mem_cfg_status_t;

endpackage
`default_nettype wire

// File: rtl/mem_config_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : config_i / mem_config_i
// Description : Config register bus and per-stream buffer descriptor handshake.
// Revision    : 1.0
// ============================================================================
interface config_i;
    import mem_config_queue_pkg::*;

    logic [CFG_ADDR_W-1:0] wr_addr;
    logic [CFG_DATA_W-1:0] wr_data;
    logic                  wr_valid;
    logic [CFG_ADDR_W-1:0] rd_addr;
    logic [CFG_DATA_W-1:0] rd_data;

    modport m (output wr_addr, wr_data, wr_valid, rd_addr, input rd_data);
    modport s (input wr_addr, wr_data, wr_valid, rd_addr, output rd_data);
endinterface

interface mem_config_i;
    import mem_config_queue_pkg::*;

    logic    valid;
    logic    ready;
    buffer_t buffer;

    modport m (output valid, buffer, input ready);
    modport s (input valid, buffer, output ready);
endinterface
`default_nettype wire

// File: rtl/mem_config_queue_channel.sv
`default_nettype none
// ============================================================================
// Module      : mem_config_queue_channel
// Description : One stream: staged vaddr, descriptor FIFO, sticky error flags.
// Revision    : 1.0
// ============================================================================
module mem_config_queue_channel
    import mem_config_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_vaddr,
    input  logic                  i_wr_size,
    input  logic                  i_wr_ctrl,
    input  logic [CFG_DATA_W-1:0] i_wr_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output buffer_t               o_buffer,
    output mem_cfg_status_t       o_status
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(DEPTH);

    buffer_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    vaddress_t          r_vaddr;
    logic               r_staged;
    logic               r_ovf;
    logic               r_novaddr;
    logic               r_zero;

    logic        w_empty;
    logic        w_pop;
    logic        w_full_after_pop;
    logic        w_push;
    logic        w_flush;
    logic        w_clear;
    alloc_size_t w_size;
    logic        w_unused_bits;

    assign w_size           = i_wr_data[SIZE_W-1:0];
    assign w_empty          = (r_count == '0);
    assign w_pop            = !w_empty && i_ready;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the commit.
    assign w_full_after_pop = (r_count == c_full) && !w_pop;
    assign w_push           = i_wr_size && r_staged && (w_size != '0) && !w_full_after_pop;
    assign w_flush          = i_wr_ctrl && i_wr_data[0];
    assign w_clear          = i_wr_ctrl && i_wr_data[1];
    assign w_unused_bits    = ^i_wr_data[CFG_DATA_W-1:VADDR_W];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{vaddr: r_vaddr, size: w_size};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vaddr  <= '0;
            r_staged <= 1'b0;
        end else if (w_flush) begin
            // Discarding everything, including an entry handshaken this cycle.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
            r_staged <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_ptr_w + 1)'(w_push) - (c_ptr_w + 1)'(w_pop);
            if (i_wr_vaddr) begin
                r_vaddr  <= i_wr_data[VADDR_W-1:0];
                r_staged <= 1'b1;
            end else if (i_wr_size) begin
                r_staged <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_novaddr <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_clear) begin
            r_ovf     <= 1'b0;
            r_novaddr <= 1'b0;
            r_zero    <= 1'b0;
        end else if (i_wr_size) begin
            if (!r_staged)              r_novaddr <= 1'b1;
            else if (w_size == '0)      r_zero    <= 1'b1;
            else if (w_full_after_pop)  r_ovf     <= 1'b1;
        end
    end

    assign o_valid  = !w_empty;
    assign o_buffer = w_empty ? '0 : r_mem[r_rd_ptr];

    assign o_status.occupancy = 8'(r_count);
    assign o_status.staged    = r_staged;
    assign o_status.ovf       = r_ovf;
    assign o_status.novaddr   = r_novaddr;
    assign o_status.zero      = r_zero;

endmodule
`default_nettype wire

// File: rtl/mem_config_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_config_queue
// Description : Register decode and STATUS read mux over NUM_STREAMS channels.
// Revision    : 1.0
// ============================================================================
module mem_config_queue
    import mem_config_queue_pkg::*;
#(
    parameter int NUM_STREAMS = 1,
    parameter int DEPTH       = 4,
    parameter int ADDR_OFFSET = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    config_i.s      conf,
    mem_config_i.m  out [NUM_STREAMS]
);

    mem_cfg_status_t       w_status [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] w_rd_hit;
    logic [CFG_DATA_W-1:0] w_rd_data;
    logic [CFG_DATA_W-1:0] r_rd_data;

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
        localparam logic [CFG_ADDR_W-1:0] c_base =
            CFG_ADDR_W'(ADDR_OFFSET + MEM_CFG_REGS_PER_STREAM * g);

        mem_config_queue_channel #(
            .DEPTH (DEPTH)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_vaddr (conf.wr_valid && (conf.wr_addr == c_base)),
            .i_wr_size  (conf.wr_valid && (conf.wr_addr == c_base + CFG_ADDR_W'(1))),
            .i_wr_ctrl  (conf.wr_valid && (conf.wr_addr == c_base + CFG_ADDR_W'(3))),
            .i_wr_data  (conf.wr_data),
            .i_ready    (out[g].ready),
            .o_valid    (out[g].valid),
            .o_buffer   (out[g].buffer),
            .o_status   (w_status[g])
        );

        assign w_rd_hit[g] = (conf.rd_addr == c_base + CFG_ADDR_W'(2));
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (w_rd_hit[i]) begin
                w_rd_data = {{(CFG_DATA_W - $bits(mem_cfg_status_t)){1'b0}}, w_status[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= w_rd_data;
    end

    assign conf.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_config_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_config_queue
// Description : Self-checking bench: queue-based reference model plus directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_mem_config_queue;
    import mem_config_queue_pkg::*;

    localparam int NS   = 3;
    localparam int DEP  = 4;
    localparam int BASE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS-1:0] rdy = '0;
    logic [NS-1:0] dut_valid;
    buffer_t       dut_buf [NS];

    int n_total = 0;
    int n_pass  = 0;

    config_i     conf_if ();
    mem_config_i out_if [NS] ();

    mem_config_queue #(
        .NUM_STREAMS (NS),
        .DEPTH       (DEP),
        .ADDR_OFFSET (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .conf  (conf_if),
        .out   (out_if)
    );

    for (genvar g = 0; g < NS; g++) begin : g_tap
        assign out_if[g].ready = rdy[g];
        assign dut_valid[g]    = out_if[g].valid;
        assign dut_buf[g]      = out_if[g].buffer;
    end

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: descriptor queues and flags driven by the register rules.
    buffer_t          mq [NS][$];
    logic             m_staged [NS] = '{default: 1'b0};
    vaddress_t        m_vaddr  [NS] = '{default: '0};
    logic             m_ovf    [NS] = '{default: 1'b0};
    logic             m_nov    [NS] = '{default: 1'b0};
    logic             m_zero   [NS] = '{default: 1'b0};
    logic [63:0]      m_rd = '0;
    logic [63:0]      rd_next;
    int               a_off, s_idx;

    function automatic logic [63:0] model_status(input int s);
        logic [63:0] v;
        v = 64'(mq[s].size());
        if (m_staged[s]) v += 64'h100;
        if (m_ovf[s])    v += 64'h200;
        if (m_nov[s])    v += 64'h400;
        if (m_zero[s])   v += 64'h800;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                mq[s].delete();
                m_staged[s] = 1'b0; m_vaddr[s] = '0;
                m_ovf[s] = 1'b0; m_nov[s] = 1'b0; m_zero[s] = 1'b0;
            end
            m_rd = '0;
        end else begin
            rd_next = '0;
            for (int s = 0; s < NS; s++)
                if (int'(conf_if.rd_addr) == BASE + 4*s + 2) rd_next = model_status(s);
            for (int s = 0; s < NS; s++)
                if (mq[s].size() > 0 && rdy[s]) void'(mq[s].pop_front());
            if (conf_if.wr_valid) begin
                a_off = int'(conf_if.wr_addr) - BASE;
                if (a_off >= 0 && a_off < 4*NS) begin
                    s_idx = a_off / 4;
                    case (a_off % 4)
                        0: begin
                            m_vaddr[s_idx]  = conf_if.wr_data[VADDR_W-1:0];
                            m_staged[s_idx] = 1'b1;
                        end
                        1: begin
                            if (!m_staged[s_idx]) m_nov[s_idx] = 1'b1;
                            else if (conf_if.wr_data[SIZE_W-1:0] == 0) m_zero[s_idx] = 1'b1;
                            else if (mq[s_idx].size() == DEP) m_ovf[s_idx] = 1'b1;
                            else mq[s_idx].push_back({m_vaddr[s_idx], conf_if.wr_data[SIZE_W-1:0]});
                            m_staged[s_idx] = 1'b0;
                        end
                        3: begin
                            if (conf_if.wr_data[1]) begin
                                m_ovf[s_idx] = 1'b0; m_nov[s_idx] = 1'b0; m_zero[s_idx] = 1'b0;
                            end
                            if (conf_if.wr_data[0]) begin
                                mq[s_idx].delete();
                                m_staged[s_idx] = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            m_rd = rd_next;
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            check($sformatf("cmp_valid_s%0d", s), 80'(dut_valid[s]), 80'(mq[s].size() > 0));
            check($sformatf("cmp_buf_s%0d", s), dut_buf[s], (mq[s].size() > 0) ? mq[s][0] : '0);
        end
        check("cmp_rd_data", 80'(conf_if.rd_data), 80'(m_rd));
    end

    task automatic tick();
        @(negedge clk);
        conf_if.wr_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        @(negedge clk);
        conf_if.wr_valid = 1'b1;
        conf_if.wr_addr  = 8'(a);
        conf_if.wr_data  = d;
    endtask

    task automatic rd_status(input int a, input logic [63:0] exp, input string name);
        @(negedge clk);
        conf_if.wr_valid = 1'b0;
        conf_if.rd_addr  = 8'(a);
        @(negedge clk);
        check(name, 80'(conf_if.rd_data), 80'(exp));
        conf_if.rd_addr = '0;
    endtask

    initial begin
        conf_if.wr_valid = 1'b0;
        conf_if.wr_addr  = '0;
        conf_if.wr_data  = '0;
        conf_if.rd_addr  = '0;
        repeat (2) @(negedge clk);
        check("reset_valid0", 80'(dut_valid[0]), 80'(0));
        check("reset_rd_data", 80'(conf_if.rd_data), 80'(0));
        rst_n = 1'b1;

        // Single pair, one-cycle latency
        wr(8, 64'h1000); wr(9, 64'h40); tick();
        check("t1_valid", 80'(dut_valid[0]), 80'(1));
        check("t1_buf", dut_buf[0], {48'h1000, 32'h40});
        rd_status(10, 64'h1, "t1_status");
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        check("t1_drained", 80'(dut_valid[0]), 80'(0));

        // Overflow on the fifth post
        for (int i = 0; i < 5; i++) begin
            wr(8, 64'h2000 + 64'(i) * 64'h100);
            wr(9, 64'h10 + 64'(i));
        end
        rd_status(10, 64'h204, "t2_status_ovf");
        check("t2_head", dut_buf[0], {48'h2000, 32'h10});
        rdy[0] = 1'b1; tick();
        check("t2_second", dut_buf[0], {48'h2100, 32'h11});
        repeat (3) tick();
        rdy[0] = 1'b0;
        check("t2_empty", 80'(dut_valid[0]), 80'(0));
        wr(11, 64'h2);

        // Missing vaddr, zero size, flag clear
        wr(9, 64'h20);
        rd_status(10, 64'h400, "t3_novaddr");
        check("t3_no_push", 80'(dut_valid[0]), 80'(0));
        wr(8, 64'h3000);
        rd_status(10, 64'h500, "t3_staged");
        wr(9, 64'h0);
        rd_status(10, 64'hC00, "t3_zero");
        wr(11, 64'h2);
        rd_status(10, 64'h0, "t3_cleared");

        // Push into a full FIFO while it pops
        for (int i = 0; i < 4; i++) begin
            wr(8, 64'h4000 + 64'(i) * 64'h100);
            wr(9, 64'(i + 1));
        end
        wr(8, 64'h5000);
        wr(9, 64'h5); rdy[0] = 1'b1;
        tick(); rdy[0] = 1'b0;
        check("t4_head", dut_buf[0], {48'h4100, 32'h2});
        rd_status(10, 64'h4, "t4_status_full_no_ovf");
        rdy[0] = 1'b1;
        repeat (4) tick();
        rdy[0] = 1'b0;
        check("t4_drained", 80'(dut_valid[0]), 80'(0));

        // Flush keeps flags; handshake in the flush cycle
        wr(9, 64'h7);
        for (int i = 0; i < 3; i++) begin
            wr(8, 64'h6000 + 64'(i) * 64'h100);
            wr(9, 64'h60 + 64'(i));
        end
        wr(11, 64'h1); rdy[0] = 1'b1;
        tick(); rdy[0] = 1'b0;
        check("t5_flushed", 80'(dut_valid[0]), 80'(0));
        rd_status(10, 64'h400, "t5_flags_kept");
        wr(8, 64'h7000); wr(9, 64'h70); tick();
        check("t5_after_flush", dut_buf[0], {48'h7000, 32'h70});
        rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
        wr(11, 64'h2);

        // Stream isolation, unmapped accesses, async reset
        wr(8, 64'hA000); wr(16, 64'hB000); wr(9, 64'hA1); wr(17, 64'hB2);
        wr(20, 64'h123); wr(7, 64'h456); tick();
        check("t6_s0_buf", dut_buf[0], {48'hA000, 32'hA1});
        check("t6_s2_buf", dut_buf[2], {48'hB000, 32'hB2});
        check("t6_s1_idle", 80'(dut_valid[1]), 80'(0));
        rd_status(18, 64'h1, "t6_s2_status");
        rd_status(14, 64'h0, "t6_s1_status");
        rd_status(20, 64'h0, "t6_unmapped_read");
        rd_status(10, 64'h1, "t6_s0_status");
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid0", 80'(dut_valid[0]), 80'(0));
        check("t6_rst_valid2", 80'(dut_valid[2]), 80'(0));
        check("t6_rst_rd_data", 80'(conf_if.rd_data), 80'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_status(18, 64'h0, "t6_post_rst_s2");
        rd_status(10, 64'h0, "t6_post_rst_s0");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
